// File: rtl/skin_pkg.sv
// Shared constants and types for the skin-detect frame controller.
//   - Power-on defaults for the Cr/Cb thresholds
//   - Config address map
//   - FSM state encoding
//   - Threshold bundle type and its reset value
package skin_pkg;

  localparam logic [7:0] CR_LO_DEF = 8'd133;
  localparam logic [7:0] CR_HI_DEF = 8'd180;
  localparam logic [7:0] CB_LO_DEF = 8'd91;
  localparam logic [7:0] CB_HI_DEF = 8'd112;

  localparam logic [1:0] CFG_CR_LO = 2'd0;
  localparam logic [1:0] CFG_CR_HI = 2'd1;
  localparam logic [1:0] CFG_CB_LO = 2'd2;
  localparam logic [1:0] CFG_CB_HI = 2'd3;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_FVAL = 2'd1,
    ACTIVE    = 2'd2,
    LATCH     = 2'd3
  } state_e;

  // Window thresholds: lo is inclusive, hi is exclusive.
  typedef struct packed {
    logic [7:0] cr_lo;
    logic [7:0] cr_hi;
    logic [7:0] cb_lo;
    logic [7:0] cb_hi;
  } thr_t;

  function automatic thr_t thr_default();
    thr_t t;
    t.cr_lo = CR_LO_DEF;
    t.cr_hi = CR_HI_DEF;
    t.cb_lo = CB_LO_DEF;
    t.cb_hi = CB_HI_DEF;
    return t;
  endfunction

endpackage

// File: rtl/skin_frame_ctrl_if.sv
// Threshold config bus between the frame FSM and the threshold register bank.
//   we/addr/data : shadow register write port
//   commit       : copy shadow -> active (frame start)
//   active       : thresholds currently in force
interface skin_frame_ctrl_if;
  import skin_pkg::*;

  logic       we;
  logic [1:0] addr;
  logic [7:0] data;
  logic       commit;
  thr_t       active;

  modport master (output we, addr, data, commit, input active);
  modport slave  (input we, addr, data, commit, output active);
endinterface

// File: rtl/skin_cfg_regs.sv
// Shadow + active threshold registers.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   cfg (slave)   : writes land in shadow; commit copies shadow into active.
// A write in the commit cycle still lands in shadow, but the commit copies the
// pre-write shadow value, so the new value is used starting next frame.
module skin_cfg_regs
  import skin_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  skin_frame_ctrl_if.slave cfg
);

  thr_t shadow_q, shadow_d;
  thr_t active_q;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg.we) begin
      case (cfg.addr)
        CFG_CR_LO: shadow_d.cr_lo = cfg.data;
        CFG_CR_HI: shadow_d.cr_hi = cfg.data;
        CFG_CB_LO: shadow_d.cb_lo = cfg.data;
        CFG_CB_HI: shadow_d.cb_hi = cfg.data;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= thr_default();
      active_q <= thr_default();
    end else begin
      shadow_q <= shadow_d;
      if (cfg.commit) active_q <= shadow_q;
    end
  end

  assign cfg.active = active_q;

endmodule

// File: rtl/skin_frame_ctrl.sv
// Frame-level controller for the YCbCr skin-detect datapath.
//   iCLK, iRST_N        : pixel clock, synchronous active-low reset
//   iFVAL, iDVAL, iMask : camera frame/line valid and detector skin mask
//   iCfgWe/Addr/Data    : threshold shadow write port
//   oCrLo..oCbHi        : thresholds in force for the current frame
//   oFrameDone          : 1-cycle pulse when the stats below update
//   oSkinCount, oX/Y*   : skin pixel count and bounding box of last frame
//   oBoxValid           : oSkinCount >= MIN_CNT
module skin_frame_ctrl
  import skin_pkg::*;
#(
  parameter int XW      = 11,
  parameter int YW      = 11,
  parameter int CW      = 22,
  parameter int MIN_CNT = 64
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic          iMask,
  input  logic          iCfgWe,
  input  logic [1:0]    iCfgAddr,
  input  logic [7:0]    iCfgData,
  output logic [7:0]    oCrLo,
  output logic [7:0]    oCrHi,
  output logic [7:0]    oCbLo,
  output logic [7:0]    oCbHi,
  output logic          oFrameDone,
  output logic [CW-1:0] oSkinCount,
  output logic [XW-1:0] oXMin,
  output logic [XW-1:0] oXMax,
  output logic [YW-1:0] oYMin,
  output logic [YW-1:0] oYMax,
  output logic          oBoxValid
);

  localparam logic [XW-1:0] X_SAT = '1;
  localparam logic [YW-1:0] Y_SAT = '1;
  localparam logic [CW-1:0] C_SAT = '1;
  localparam logic [CW:0]   MIN_W = (CW+1)'(MIN_CNT);

  skin_frame_ctrl_if cfg_bus ();

  state_e        state_q;
  logic          fval_q, dval_q;
  logic [XW-1:0] x_q, xmin_q, xmax_q;
  logic [YW-1:0] y_q, ymin_q, ymax_q;
  logic [CW-1:0] cnt_q;

  logic          done_q, bv_q;
  logic [CW-1:0] skin_q;
  logic [XW-1:0] oxmin_q, oxmax_q;
  logic [YW-1:0] oymin_q, oymax_q;

  logic rise, commit, accept, dval_fall;

  assign rise      = iFVAL & ~fval_q;
  assign commit    = (state_q == WAIT_FVAL) & rise;
  assign accept    = (state_q == ACTIVE) & iFVAL & iDVAL;
  assign dval_fall = (state_q == ACTIVE) & ~iDVAL & dval_q;

  assign cfg_bus.we     = iCfgWe;
  assign cfg_bus.addr   = iCfgAddr;
  assign cfg_bus.data   = iCfgData;
  assign cfg_bus.commit = commit;

  skin_cfg_regs u_cfg (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .cfg    (cfg_bus)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= WAIT_LOW;
      fval_q  <= 1'b0;
      dval_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      done_q  <= 1'b0;
      bv_q    <= 1'b0;
      skin_q  <= '0;
      oxmin_q <= '0;
      oxmax_q <= '0;
      oymin_q <= '0;
      oymax_q <= '0;
    end else begin
      fval_q <= iFVAL;
      dval_q <= iDVAL;
      done_q <= 1'b0;
      case (state_q)
        // Never join a frame already in progress.
        WAIT_LOW: if (!iFVAL) state_q <= WAIT_FVAL;
        WAIT_FVAL: begin
          if (commit) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (x_q != X_SAT) x_q <= x_q + 1'b1;
            if (iMask) begin
              if (cnt_q != C_SAT) cnt_q <= cnt_q + 1'b1;
              if (x_q < xmin_q) xmin_q <= x_q;
              if (x_q > xmax_q) xmax_q <= x_q;
              if (y_q < ymin_q) ymin_q <= y_q;
              if (y_q > ymax_q) ymax_q <= y_q;
            end
          end else if (dval_fall) begin
            x_q <= '0;
            if (y_q != Y_SAT) y_q <= y_q + 1'b1;
          end
          // Outputs load on entry so they and the pulse are visible in LATCH.
          if (!iFVAL) begin
            state_q <= LATCH;
            done_q  <= 1'b1;
            skin_q  <= cnt_q;
            bv_q    <= ({1'b0, cnt_q} >= MIN_W);
            // An empty frame reports a zero box, not the min=ones sentinel.
            oxmin_q <= (cnt_q == '0) ? '0 : xmin_q;
            oxmax_q <= (cnt_q == '0) ? '0 : xmax_q;
            oymin_q <= (cnt_q == '0) ? '0 : ymin_q;
            oymax_q <= (cnt_q == '0) ? '0 : ymax_q;
          end
        end
        LATCH: state_q <= WAIT_FVAL;
        default: state_q <= WAIT_LOW;
      endcase
    end
  end

  assign oCrLo      = cfg_bus.active.cr_lo;
  assign oCrHi      = cfg_bus.active.cr_hi;
  assign oCbLo      = cfg_bus.active.cb_lo;
  assign oCbHi      = cfg_bus.active.cb_hi;
  assign oFrameDone = done_q;
  assign oSkinCount = skin_q;
  assign oXMin      = oxmin_q;
  assign oXMax      = oxmax_q;
  assign oYMin      = oymin_q;
  assign oYMax      = oymax_q;
  assign oBoxValid  = bv_q;

endmodule

// File: tb/tb_skin_frame_ctrl.sv
module tb_skin_frame_ctrl;
  import skin_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fval = 1'b0, dval = 1'b0, mask = 1'b0;

  skin_frame_ctrl_if cfg ();

  // Full-size instance and a narrow one for saturation behaviour.
  logic [7:0]  crlo0, crhi0, cblo0, cbhi0, crlo1, crhi1, cblo1, cbhi1;
  logic        done0, bv0, done1, bv1;
  logic [21:0] cnt0;
  logic [10:0] xmin0, xmax0, ymin0, ymax0, ymin1, ymax1;
  logic [3:0]  cnt1;
  logic [2:0]  xmin1, xmax1;

  skin_frame_ctrl dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iFVAL(fval), .iDVAL(dval), .iMask(mask),
    .iCfgWe(cfg.we), .iCfgAddr(cfg.addr), .iCfgData(cfg.data),
    .oCrLo(crlo0), .oCrHi(crhi0), .oCbLo(cblo0), .oCbHi(cbhi0),
    .oFrameDone(done0), .oSkinCount(cnt0),
    .oXMin(xmin0), .oXMax(xmax0), .oYMin(ymin0), .oYMax(ymax0), .oBoxValid(bv0)
  );

  skin_frame_ctrl #(.XW(3), .YW(11), .CW(4), .MIN_CNT(4)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iFVAL(fval), .iDVAL(dval), .iMask(mask),
    .iCfgWe(cfg.we), .iCfgAddr(cfg.addr), .iCfgData(cfg.data),
    .oCrLo(crlo1), .oCrHi(crhi1), .oCbLo(cblo1), .oCbHi(cbhi1),
    .oFrameDone(done1), .oSkinCount(cnt1),
    .oXMin(xmin1), .oXMax(xmax1), .oYMin(ymin1), .oYMax(ymax1), .oBoxValid(bv1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: thresholds and the stats each instance should report.
  logic [7:0] sh [4];
  logic [7:0] ac [4];
  int e_cnt [2], e_xmin [2], e_xmax [2], e_ymin [2], e_ymax [2], e_bv [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    sh[0] = CR_LO_DEF; sh[1] = CR_HI_DEF; sh[2] = CB_LO_DEF; sh[3] = CB_HI_DEF;
    for (int i = 0; i < 4; i++) ac[i] = sh[i];
    for (int d = 0; d < 2; d++) begin
      e_cnt[d] = 0; e_xmin[d] = 0; e_xmax[d] = 0;
      e_ymin[d] = 0; e_ymax[d] = 0; e_bv[d] = 0;
    end
  endtask

  task automatic chk_thr(input string tag);
    chk({tag, ".crlo0"}, 32'(crlo0), 32'(ac[0]));
    chk({tag, ".crhi0"}, 32'(crhi0), 32'(ac[1]));
    chk({tag, ".cblo0"}, 32'(cblo0), 32'(ac[2]));
    chk({tag, ".cbhi0"}, 32'(cbhi0), 32'(ac[3]));
    chk({tag, ".crlo1"}, 32'(crlo1), 32'(ac[0]));
    chk({tag, ".cbhi1"}, 32'(cbhi1), 32'(ac[3]));
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".cnt0"},  32'(cnt0),  e_cnt[0]);
    chk({tag, ".xmin0"}, 32'(xmin0), e_xmin[0]);
    chk({tag, ".xmax0"}, 32'(xmax0), e_xmax[0]);
    chk({tag, ".ymin0"}, 32'(ymin0), e_ymin[0]);
    chk({tag, ".ymax0"}, 32'(ymax0), e_ymax[0]);
    chk({tag, ".bv0"},   32'(bv0),   e_bv[0]);
    chk({tag, ".cnt1"},  32'(cnt1),  e_cnt[1]);
    chk({tag, ".xmin1"}, 32'(xmin1), e_xmin[1]);
    chk({tag, ".xmax1"}, 32'(xmax1), e_xmax[1]);
    chk({tag, ".ymin1"}, 32'(ymin1), e_ymin[1]);
    chk({tag, ".ymax1"}, 32'(ymax1), e_ymax[1]);
    chk({tag, ".bv1"},   32'(bv1),   e_bv[1]);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg.we = 1'b1; cfg.addr = a; cfg.data = d;
    tick();
    cfg.we = 1'b0;
    sh[a] = d;
  endtask

  // One frame of w x h pixels. pct<0 selects the fixed two-pixel pattern.
  task automatic run_frame(input string tag, input int w, input int h, input int pct,
                           input bit mid_wr, input logic [1:0] ma, input logic [7:0] md,
                           input bit rise_wr, input logic [1:0] ra, input logic [7:0] rd,
                           input bit rst_mid);
    int  n = 0, xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
    bit  disc = 1'b0;
    fval = 1'b0; dval = 1'($urandom_range(1)); mask = 1'($urandom_range(1));
    tick();
    dval = 1'b0; mask = 1'b0;
    tick();
    fval = 1'b1;
    if (rise_wr) begin cfg.we = 1'b1; cfg.addr = ra; cfg.data = rd; end
    tick();
    cfg.we = 1'b0;
    for (int i = 0; i < 4; i++) ac[i] = sh[i];
    if (rise_wr) sh[ra] = rd;
    chk_thr({tag, ".rise"});
    mask = 1'($urandom_range(1));
    tick();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        dval = 1'b1;
        if (pct < 0) mask = ((c == 1) && (r == 0)) || ((c == 2) && (r == 2));
        else         mask = ($urandom_range(99) < pct);
        tick();
        if (mask) begin
          n++;
          if (c < xmn) xmn = c;
          if (c > xmx) xmx = c;
          if (r < ymn) ymn = r;
          if (r > ymx) ymx = r;
        end
      end
      dval = 1'b0; mask = 1'($urandom_range(1));
      tick();
      chk({tag, ".done_in_frame"}, 32'(done0 | done1), 0);
      if (r == 0 && mid_wr) begin
        cfg_write(ma, md);
        chk_thr({tag, ".mid"});
      end
      if (r == 0 && rst_mid) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        disc = 1'b1;
        chk_thr({tag, ".rst"});
        chk_stats({tag, ".rst"});
        chk({tag, ".rst_done"}, 32'(done0 | done1), 0);
      end
    end
    fval = 1'b0; dval = 1'b0; mask = 1'b0;
    tick();
    if (!disc) begin
      if (n == 0) begin
        for (int d = 0; d < 2; d++) begin
          e_cnt[d] = 0; e_xmin[d] = 0; e_xmax[d] = 0;
          e_ymin[d] = 0; e_ymax[d] = 0; e_bv[d] = 0;
        end
      end else begin
        e_cnt[0]  = sat(n, (1 << 22) - 1); e_cnt[1]  = sat(n, 15);
        e_xmin[0] = sat(xmn, 2047);        e_xmin[1] = sat(xmn, 7);
        e_xmax[0] = sat(xmx, 2047);        e_xmax[1] = sat(xmx, 7);
        for (int d = 0; d < 2; d++) begin
          e_ymin[d] = sat(ymn, 2047);
          e_ymax[d] = sat(ymx, 2047);
        end
        e_bv[0] = (e_cnt[0] >= 64) ? 1 : 0;
        e_bv[1] = (e_cnt[1] >= 4) ? 1 : 0;
      end
    end
    chk({tag, ".done0"}, 32'(done0), disc ? 0 : 1);
    chk({tag, ".done1"}, 32'(done1), disc ? 0 : 1);
    chk_stats({tag, ".latch"});
    tick();
    chk({tag, ".done_after"}, 32'(done0 | done1), 0);
    chk_stats({tag, ".hold"});
    chk_thr({tag, ".hold"});
  endtask

  initial begin
    cfg.we = 1'b0; cfg.addr = 2'd0; cfg.data = 8'd0;
    cfg.commit = 1'b0; cfg.active = '0;
    model_reset();

    // Reset state
    tick(); tick();
    chk_thr("reset");
    chk_stats("reset");
    chk("reset.done", 32'(done0 | done1), 0);
    rst_n = 1'b1;

    // Directed 4x3 frame with skin at (1,0) and (2,2)
    run_frame("t1", 4, 3, -1, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);
    // Mid-frame write holds off until next frame start
    run_frame("t2a", 6, 3, 40, 1, CFG_CR_LO, 8'd140, 0, 2'd0, 8'd0, 0);
    // Write on the commit cycle applies one frame later
    run_frame("t2b", 6, 3, 40, 0, 2'd0, 8'd0, 1, CFG_CB_HI, 8'd120, 0);
    // Lo >= Hi passes through unchanged
    run_frame("t2c", 5, 2, 50, 1, CFG_CR_LO, 8'd200, 0, 2'd0, 8'd0, 0);
    run_frame("t2d", 5, 2, 50, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);
    // Empty frame
    run_frame("t3", 8, 4, 0, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);
    // Saturation on the narrow instance: 20 skin pixels, 10-wide lines
    run_frame("t5", 10, 2, 100, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);

    // Reset released while a frame is in progress
    rst_n = 1'b0; fval = 1'b1; dval = 1'b1; mask = 1'b1;
    tick();
    model_reset();
    chk_thr("t4.rst");
    chk_stats("t4.rst");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dval = (i % 4) != 3;
      tick();
      chk("t4.no_done", 32'(done0 | done1), 0);
    end
    fval = 1'b0; dval = 1'b0; mask = 1'b0;
    tick();
    chk("t4.fall_done", 32'(done0 | done1), 0);
    chk_stats("t4.fall");
    tick();
    chk("t4.fall_done2", 32'(done0 | done1), 0);
    run_frame("t4.next", 7, 4, 60, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);

    // Non-default thresholds, then a one-cycle reset mid-frame
    run_frame("t6a", 4, 2, 50, 1, CFG_CB_LO, 8'd77, 0, 2'd0, 8'd0, 0);
    run_frame("t6b", 6, 4, 80, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 1);
    run_frame("t6c", 6, 4, 70, 0, 2'd0, 8'd0, 0, 2'd0, 8'd0, 0);

    // Randomized frames and config writes
    for (int k = 0; k < 10; k++) begin
      run_frame("rnd", int'($urandom_range(16, 3)), int'($urandom_range(9, 2)),
                int'($urandom_range(95, 5)),
                1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)),
                1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
